// File: rtl/iter_alu.sv
// iter_alu: execution-stage ALU with single-cycle logic/arith ops and a
// WIDTH-cycle iterative shift-add multiplier. Option: ITER_ALU_MULT_HI_EN.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
`ifdef ITER_ALU_MULT_HI_EN
    ,
    output logic [WIDTH-1:0] hi_o
`endif
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               is_mul;
    logic               last;
    logic               slt;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [CNT_W-1:0]   cnt;
    // Upper half accumulates, lower half holds the shifting multiplier.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     add_hi;
    logic [WIDTH-1:0]   mcand;
    logic               sign;
    logic [WIDTH-1:0]   prod_lo;

    assign is_mul = (ALUCtrl_i == OP_MUL);
    assign last   = (state == MUL) && (cnt == CNT_W'(1));
    assign slt    = $signed(src1_i) < $signed(src2_i);
    assign abs_a  = src1_i[WIDTH-1] ? (WIDTH'(0) - src1_i) : src1_i;
    assign abs_b  = src2_i[WIDTH-1] ? (WIDTH'(0) - src2_i) : src2_i;

    // One shift-add iteration; the carry lands in the top product bit.
    assign add_hi   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign acc_step = {add_hi, acc[WIDTH-1:1]};
    // Low half of a two's-complement negation depends only on low bits.
    assign prod_lo  = sign ? (WIDTH'(0) - acc_step[WIDTH-1:0])
                           : acc_step[WIDTH-1:0];

`ifdef ITER_ALU_MULT_HI_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = sign ? ((2*WIDTH)'(0) - acc_step) : acc_step;
`endif

    // Single-cycle result for the currently presented code.
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_ADD:  alu_res = src1_i + src2_i;
            OP_SUB:  alu_res = src1_i - src2_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
            default: alu_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, handshake outputs and operation accept.
    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept = start_i;
            end
            MUL: begin
                busy_o = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                accept    = start_i;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) state_nxt = is_mul ? MUL : DONE;
    end

    // Datapath: operand capture, iteration and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o <= '0;
            zero_o   <= 1'b1;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            sign     <= 1'b0;
`ifdef ITER_ALU_MULT_HI_EN
            hi_o     <= '0;
`endif
        end else if (accept) begin
            if (is_mul) begin
                acc   <= {{WIDTH{1'b0}}, abs_b};
                mcand <= abs_a;
                sign  <= src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
                cnt   <= CNT_W'(WIDTH);
            end else begin
                result_o <= alu_res;
                zero_o   <= (alu_res == '0);
`ifdef ITER_ALU_MULT_HI_EN
                hi_o     <= '0;
`endif
            end
        end else if (state == MUL) begin
            acc <= acc_step;
            cnt <= cnt - CNT_W'(1);
            if (last) begin
                result_o <= prod_lo;
                zero_o   <= (prod_lo == '0);
`ifdef ITER_ALU_MULT_HI_EN
                hi_o     <= prod[2*WIDTH-1:WIDTH];
`endif
            end
        end
    end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Execution-stage ALU that consumes the 4-bit ALU control code produced by the ALU controller.
- Codes: 0 and, 1 or, 2 add, 3 mult, 6 sub, 7 slt.
- Logic/arith ops complete in one registered cycle. mult runs as an iterative shift-add over WIDTH cycles.
- A start/busy/done handshake lets the multi-cycle CPU stall while a mult is in progress.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be >= 4.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  request an operation; sampled only when busy_o=0.
- ALUCtrl_i  input  4  operation code (see Overview).
- src1_i  input  WIDTH  operand A, two's complement.
- src2_i  input  WIDTH  operand B, two's complement.
- result_o  output  WIDTH  result; for mult, low WIDTH bits of the product.
- zero_o  output  1  1 when result_o == 0.
- busy_o  output  1  mult iteration in progress.
- done_o  output  1  one-cycle pulse; result_o/zero_o are valid and updated this cycle.

Behaviour:
- Reset values (rst_i=1 at an edge): state=IDLE, result_o=0, zero_o=1, busy_o=0, done_o=0, counter=0, internal product/multiplicand cleared. Reset overrides start_i.
- States: IDLE, MUL, DONE.
  - busy_o=1 only in MUL.
  - done_o=1 only in DONE.
- Operation accept: start_i=1 in IDLE or DONE, i.e. busy_o=0. Back-to-back issue from DONE is legal.
- Operands and ALUCtrl_i are captured at the accepting edge. Later input changes have no effect on that operation.
- Single-cycle ops (codes 0,1,2,6,7):
  - Result is registered at the accepting edge; state goes to DONE.
  - Start accepted at edge N gives done_o=1 in cycle N+1.
  - add/sub wrap modulo 2^WIDTH. No overflow flag.
  - slt is signed: result = 1 if src1 < src2 as two's complement, else 0, zero-extended.
- Undefined codes (4,5,8..15): treated as a single-cycle op with result 0 and zero_o=1; done_o still pulses.
- mult (code 3):
  - Accepting edge captures |src1| and |src2| and sign = src1[MSB] XOR src2[MSB]. Clears the 2*WIDTH accumulator, loads counter=WIDTH, state goes to MUL.
  - Each MUL cycle:
    - if the multiplier LSB is 1, add the multiplicand into the accumulator upper half;
    - shift right by 1;
    - counter decrements.
  - When counter reaches 1 and that iteration completes, go to DONE.
  - On the DONE entry edge, result_o is loaded with the final product (negated in 2*WIDTH bits if sign=1), low WIDTH bits.
  - Latency: start accepted at edge N gives done_o=1 in cycle N+WIDTH+1. busy_o is high for exactly WIDTH cycles.
  - start_i during MUL is ignored, not queued.
  - Most-negative operand (-2^(WIDTH-1)): its magnitude is exact in WIDTH unsigned bits; the product must be correct.
- DONE:
  - If start_i=1, accept the new op (same rules as IDLE).
  - Otherwise go to IDLE.
- result_o/zero_o hold their value from the last DONE until the next DONE or reset.
- zero_o is registered alongside result_o and is always consistent with it.
- Reset asserted mid-MUL aborts the operation: no done_o pulse, outputs return to reset values on the next edge.

Optional Feature:
- Macro: ITER_ALU_MULT_HI_EN
- Defined:
  - Adds output port hi_o (WIDTH) holding the upper WIDTH bits of the signed 2*WIDTH product.
  - hi_o is loaded on the same edge as result_o for a mult.
  - hi_o is cleared to 0 on reset and on any non-mult completion.
- Not defined:
  - hi_o port does not exist.
  - Upper accumulator bits are still computed internally, but only the low WIDTH bits are exported.
  - All other behaviour is identical.

Test Plan:
- Reset with start_i=1, ALUCtrl_i=2, operands 5 and 7 held high for 2 cycles -> result_o=0, zero_o=1, busy_o=0, done_o=0 throughout reset.
- add, then sub: add 0x7FFFFFFF + 1 -> done_o at N+1, result_o=0x80000000, zero_o=0. Issue sub 9-9 in the DONE cycle -> done_o again the next cycle, result_o=0, zero_o=1.
- slt signed: src1=0xFFFFFFFF (-1), src2=1 -> result_o=1. Swap the operands -> result_o=0.
- mult -3*5:
  - busy_o high for exactly 32 cycles; done_o at N+33; result_o=0xFFFFFFF1.
  - With ITER_ALU_MULT_HI_EN defined: hi_o=0xFFFFFFFF.
  - start_i pulsed with and 1,1 during MUL -> ignored; result unchanged.
- mult 0x80000000*0x80000000 -> result_o=0. With ITER_ALU_MULT_HI_EN defined: hi_o=0x40000000.
- Abort and undefined code:
  - Start mult 7*7; assert rst_i at cycle N+10 -> no done_o pulse, result_o=0 after the edge.
  - Then issue code 5 -> done_o at N+1, result_o=0, zero_o=1.
